// File: rtl/instr_loader.sv
// instr_loader: boot-time loader that assembles a checksummed little-endian byte stream
// into instruction memory writes and holds the core in reset until the image is verified.
module instr_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [WIDTH-1:0]      imem_addr,
    output logic [WIDTH-1:0]      imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    typedef enum logic [2:0] {LEN, DATA, CSUM, DONE, ERR} state_t;
    state_t                state;
    logic [1:0]            cnt;
    logic [31:0]           len;
    logic [7:0]            sum;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [23:0]           sh;
    logic                  acc;
    logic [7:0]            sum_n;
    logic [31:0]           len_n;
    logic [31:0]           word_n;
    logic [ADDR_WIDTH:0]   wl_n;
    assign acc    = byte_valid && byte_ready;
    assign sum_n  = sum + byte_data;
    assign len_n  = {byte_data, len[31:8]};
    assign word_n = {byte_data, sh};
    assign wl_n   = words_loaded + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LEN;
            cnt          <= '0;
            len          <= '0;
            sum          <= '0;
            word_idx     <= '0;
            sh           <= '0;
            byte_ready   <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we    <= 1'b0;
            // terminal transitions below override this to drop ready on the same edge
            byte_ready <= state inside {LEN, DATA, CSUM};
            if (acc) begin
                sum <= sum_n;
                cnt <= cnt + 2'd1;
                case (state)
                    LEN: begin
                        len <= len_n;
                        if (cnt == 2'd3) begin
                            if (len_n > (32'd1 << ADDR_WIDTH)) begin
                                state      <= ERR;
                                err        <= 1'b1;
                                byte_ready <= 1'b0;
                            end else begin
                                state <= (len_n == 32'd0) ? CSUM : DATA;
                            end
                        end
                    end
                    DATA: begin
                        sh <= word_n[31:8];
                        if (cnt == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= WIDTH'(word_n);
                            imem_addr    <= WIDTH'({word_idx, 2'b00});
                            word_idx     <= word_idx + 1'b1;
                            words_loaded <= wl_n;
                            if (wl_n == len[ADDR_WIDTH:0])
                                state <= CSUM;
                        end
                    end
                    CSUM: begin
                        byte_ready <= 1'b0;
                        if (sum_n == 8'd0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized self-checking bench; expected writes and final status
// are derived from the whole byte image by a stream-level reference model.
module tb_instr_loader;
    localparam int AW = 12;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_ready, imem_we, cpu_rst, done, err;
    logic [31:0]   imem_addr, imem_wdata;
    logic [AW:0]   words_loaded;
    logic [7:0]    stream[$];
    logic [63:0]   wr[$];
    logic [31:0]   exp_w[$];
    bit            exp_done, exp_err;
    int            cmp = 0;
    int            bad = 0;

    instr_loader #(.WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we) wr.push_back({imem_addr, imem_wdata});

    task automatic build(input int unsigned n, input bit fixed, input int delta);
        logic [31:0] w;
        logic [7:0]  s;
        stream.delete();
        s = 8'd0;
        for (int k = 0; k < 4; k++) stream.push_back(8'(n >> (8 * k)));
        for (int unsigned i = 0; i < n; i++) begin
            w = fixed ? ((i == 0) ? 32'h00500093 : 32'h00100113) : $urandom;
            for (int k = 0; k < 4; k++) stream.push_back(8'(w >> (8 * k)));
        end
        foreach (stream[i]) s += stream[i];
        s = 8'd0 - s;
        stream.push_back(s + 8'(delta));
    endtask

    task automatic model();
        int unsigned n;
        logic [7:0]  s;
        s = 8'd0;
        exp_w.delete();
        n = {stream[3], stream[2], stream[1], stream[0]};
        foreach (stream[i]) s += stream[i];
        if (n > (32'd1 << AW)) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            return;
        end
        for (int unsigned i = 0; i < n; i++)
            exp_w.push_back({stream[4*i+7], stream[4*i+6], stream[4*i+5], stream[4*i+4]});
        exp_done = (s == 8'd0);
        exp_err  = !exp_done;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
    task automatic send(input int mode);
        int idx = 0;
        int cyc = 0;
        int lim = 4 * stream.size() + 20;
        while (idx < stream.size() && cyc < lim) begin
            @(negedge clk);
            cyc++;
            if (byte_ready && (mode == 0 || (mode == 1 && cyc % 2 == 0) ||
                               (mode == 2 && $urandom_range(0, 2) != 0))) begin
                byte_valid = 1'b1;
                byte_data  = stream[idx];
                idx++;
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
        cmp++;
        if (idx != stream.size()) begin
            bad++;
            $display("FAIL send_timeout: accepted %0d bytes, required %0d", idx, stream.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        cmp++;
        if ({byte_ready, imem_we, cpu_rst, done, err} !== 5'b00100) begin
            bad++;
            $display("FAIL reset_flags: ready/we/cpu_rst/done/err=%b required 00100",
                     {byte_ready, imem_we, cpu_rst, done, err});
        end
        cmp++;
        if (imem_addr !== 32'd0 || imem_wdata !== 32'd0 || words_loaded !== '0) begin
            bad++;
            $display("FAIL reset_regs: addr=%h wdata=%h words=%0d required 0/0/0",
                     imem_addr, imem_wdata, words_loaded);
        end
        rst = 1'b0;
        @(negedge clk);
        cmp++;
        if (byte_ready !== 1'b1 || cpu_rst !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: ready=%b cpu_rst=%b required 1/1", byte_ready, cpu_rst);
        end
    endtask

    task automatic test_image(input string name, input int unsigned n, input int mode,
                              input int delta, input bit fixed);
        wr.delete();
        build(n, fixed, delta);
        model();
        send(mode);
        cmp++;
        if ({done, err, cpu_rst} !== {exp_done, exp_err, ~exp_done}) begin
            bad++;
            $display("FAIL %s_status_latency: done/err/cpu_rst=%b required %b", name,
                     {done, err, cpu_rst}, {exp_done, exp_err, ~exp_done});
        end
        repeat (2) @(negedge clk);
        cmp++;
        if (wr.size() != exp_w.size()) begin
            bad++;
            $display("FAIL %s_write_count: got %0d writes required %0d", name, wr.size(), exp_w.size());
        end
        foreach (exp_w[i]) if (i < wr.size()) begin
            cmp++;
            if (wr[i] !== {32'(i * 4), exp_w[i]}) begin
                bad++;
                $display("FAIL %s_write[%0d]: got addr/data=%h required %h", name, i, wr[i],
                         {32'(i * 4), exp_w[i]});
            end
        end
        cmp++;
        if (words_loaded !== (AW + 1)'(exp_w.size())) begin
            bad++;
            $display("FAIL %s_words_loaded: got %0d required %0d", name, words_loaded, exp_w.size());
        end
        cmp++;
        if ({done, err, cpu_rst, byte_ready} !== {exp_done, exp_err, ~exp_done, 1'b0}) begin
            bad++;
            $display("FAIL %s_final: done/err/cpu_rst/ready=%b required %b", name,
                     {done, err, cpu_rst, byte_ready}, {exp_done, exp_err, ~exp_done, 1'b0});
        end
    endtask

    task automatic test_overflow();
        do_reset();
        wr.delete();
        build((1 << AW) + 1, 1'b0, 0);
        stream = stream[0:3];
        send(0);
        @(negedge clk);
        cmp++;
        if ({err, done, cpu_rst, byte_ready} !== 4'b1010 || wr.size() != 0 || words_loaded !== '0) begin
            bad++;
            $display("FAIL overflow: err/done/cpu_rst/ready=%b writes=%0d words=%0d required 1010/0/0",
                     {err, done, cpu_rst, byte_ready}, wr.size(), words_loaded);
        end
    endtask

    task automatic test_zero_and_ignore();
        do_reset();
        test_image("zero_len", 0, 0, 0, 1'b0);
        wr.delete();
        repeat (4) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        cmp++;
        if ({done, err, cpu_rst, byte_ready} !== 4'b1000 || wr.size() != 0 || words_loaded !== '0) begin
            bad++;
            $display("FAIL done_ignores_bytes: done/err/cpu_rst/ready=%b writes=%0d words=%0d required 1000/0/0",
                     {done, err, cpu_rst, byte_ready}, wr.size(), words_loaded);
        end
    endtask

    task automatic test_abort();
        do_reset();
        build(2, 1'b1, 0);
        stream = stream[0:9];
        send(0);
        wr.delete();
        do_reset();
        repeat (2) @(negedge clk);
        cmp++;
        if (wr.size() != 0 || words_loaded !== '0 || {done, err, cpu_rst, byte_ready} !== 4'b0011) begin
            bad++;
            $display("FAIL abort_clear: writes=%0d words=%0d done/err/cpu_rst/ready=%b required 0/0/0011",
                     wr.size(), words_loaded, {done, err, cpu_rst, byte_ready});
        end
        test_image("abort_reload", 1, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_image("basic_b2b", 2, 0, 0, 1'b1);
        do_reset();
        test_image("basic_toggle", 2, 1, 0, 1'b1);
        do_reset();
        test_image("bad_csum", 1, 0, 1, 1'b0);
        test_overflow();
        test_zero_and_ignore();
        test_abort();
        for (int r = 0; r < 6; r++) begin
            do_reset();
            test_image("random", $urandom_range(1, 6), 2,
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0, 1'b0);
        end
        do_reset();
        test_image("full_capacity", 1 << AW, 0, 0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
